pc_fetch_unit: RTL and testbench
================================

Name: pc_fetch_unit

Overview:
- PC register and instruction-fetch front end of the pipelined CPU; the consumer of the next-PC value produced by the next-PC logic.
- Holds the current PC and drives it as `oldPC`.
- Fetches from instruction memory over a ready handshake.
- Maintains the IF/ID register (`id_pc`, `id_instr`, `id_valid`).
- Applies hazard-unit stalls and control-transfer flushes. On each advance, `newPC` is loaded into the PC.

Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0000, instruction word placed in IF/ID on flush or bubble.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- newPC  input  32  next PC from the next-PC logic (`oldPC`+4, branch, jump or jr target).
- redirect  input  1  ID-stage control transfer taken (jump, jr, or taken branch).
- stall  input  1  hazard unit freezes PC and IF/ID.
- imem_rdata  input  32  instruction word for `imem_addr`, valid when `imem_ready`=1.
- imem_ready  input  1  memory returns data this cycle.
- imem_req  output  1  fetch request.
- imem_addr  output  32  fetch address (equals `oldPC`).
- oldPC  output  32  current PC register.
- id_pc  output  32  PC of the instruction in ID.
- id_instr  output  32  instruction in ID.
- id_valid  output  1  ID slot holds a real instruction.

Behaviour:
- Reset (async, `rst_n`=0):
  - pc=RESET_PC; `id_pc`=0; `id_instr`=NOP_INSTR; `id_valid`=0.
  - Skid buffer empty; state=S_BOOT; `imem_req`=0.
  - Reset mid-fetch drops the access; no partial state survives.
- Memory protocol:
  - Level request, no outstanding transactions.
  - Data returned with `imem_ready`=1 belongs to the `imem_addr` of the same cycle.
  - Zero-wait memory (ready same cycle as req) is legal.
  - `imem_addr` may change while ready=0; the unit never waits on an abandoned access.
- States:
  - S_BOOT: req=0; next cycle -> S_FETCH. Gives one idle cycle after reset release.
  - S_FETCH: req=1, addr=pc. Priority order, first match wins:
    1. redirect & !stall: pc<=newPC; IF/ID<=bubble (`id_valid`=0, `id_instr`=NOP_INSTR); any returned data discarded; stay S_FETCH.
    2. stall: pc and IF/ID hold. If ready=1, capture rdata into skid buffer -> S_HOLD.
    3. ready=1: `id_instr`<=rdata; `id_pc`<=pc; `id_valid`<=1; pc<=newPC; stay S_FETCH.
    4. ready=0: IF/ID<=bubble; pc holds.
  - S_HOLD: req=0; skid buffer holds the fetched word for pc.
    1. redirect & !stall: pc<=newPC; IF/ID<=bubble; buffer cleared -> S_FETCH.
    2. stall: hold everything.
    3. Otherwise: `id_instr`<=buffer; `id_pc`<=pc; `id_valid`<=1; pc<=newPC; buffer cleared -> S_FETCH.
- Redirect while stall=1 is ignored; ID has not resolved, and the hazard unit re-presents it.
- No branch delay slot: the sequential instruction behind a taken transfer is always squashed.
- PC arithmetic:
  - 32-bit; `newPC` taken verbatim, wraps naturally.
  - Bits [1:0] passed through unchecked.
- Throughput: one instruction per cycle with zero-wait memory and no stall/redirect.
- Latency: fetch at pc in cycle N appears in ID (`id_pc`=pc) in cycle N+1.
- Outputs are registered except `imem_req` (state decode) and `imem_addr`=`oldPC`=pc register.

Test Plan:
- Reset/boot, zero-wait memory with `newPC`=`oldPC`+4:
  - `rst_n` low then high -> `oldPC`=32'h3000, req=0 for one cycle.
  - Then `id_pc` sequence 3000, 3004, 3008 on consecutive cycles with `id_valid`=1.
- Wait states: ready low 2 cycles at pc=3004 -> `id_valid`=0 for 2 cycles, `oldPC` stays 3004. On ready, `id_pc`=3004 and `id_instr`=rdata.
- Stall with data returning: stall=1 while ready=1 at pc=3008 -> S_HOLD, req=0, `id_pc`/`id_instr` unchanged. Stall drop -> `id_pc`=3008 with buffered word, `oldPC`=300C.
- Redirect: at `oldPC`=3010, redirect=1, `newPC`=3040 -> next cycle `oldPC`=3040, `id_valid`=0, `id_instr`=0. Following cycle `id_pc`=3040.
- Redirect during stall and in S_HOLD:
  - redirect=1 with stall=1 -> no PC change.
  - redirect=1 in S_HOLD with stall=0 -> buffer discarded, `oldPC`=`newPC`, bubble in ID.
- Async reset mid-stream: `rst_n`=0 mid-cycle while S_HOLD -> immediately `oldPC`=3000, `id_valid`=0, req=0, buffer empty.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - PC register, instruction fetch handshake and IF/ID register
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_3000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] newPC,
  input  logic        redirect,
  input  logic        stall,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  output logic [31:0] oldPC,
  output logic [31:0] id_pc,
  output logic [31:0] id_instr,
  output logic        id_valid
);

  // S_HOLD means the skid buffer owns the word fetched for the current pc.
  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] w_pc_nxt;
  logic [31:0] r_id_pc;
  logic [31:0] w_id_pc_nxt;
  logic [31:0] r_id_instr;
  logic [31:0] w_id_instr_nxt;
  logic        r_id_valid;
  logic        w_id_valid_nxt;
  logic [31:0] r_skid;
  logic [31:0] w_skid_nxt;
  logic        w_req;

  // State register; reset drops any in-flight access by returning to boot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_BOOT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // PC, IF/ID and skid buffer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc       <= RESET_PC;
      r_id_pc    <= 32'h0000_0000;
      r_id_instr <= NOP_INSTR;
      r_id_valid <= 1'b0;
      r_skid     <= 32'h0000_0000;
    end else begin
      r_pc       <= w_pc_nxt;
      r_id_pc    <= w_id_pc_nxt;
      r_id_instr <= w_id_instr_nxt;
      r_id_valid <= w_id_valid_nxt;
      r_skid     <= w_skid_nxt;
    end
  end

  // Next-state and datapath decode; a redirect only counts when ID is not stalled.
  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_id_pc_nxt    = r_id_pc;
    w_id_instr_nxt = r_id_instr;
    w_id_valid_nxt = r_id_valid;
    w_skid_nxt     = r_skid;
    w_req          = 1'b0;
    case (r_state)
      S_BOOT: begin
        w_state_nxt = S_FETCH;
      end
      S_FETCH: begin
        w_req = 1'b1;
        if (redirect && !stall) begin
          // Squash the sequential fetch behind the transfer; returned data is dropped.
          w_pc_nxt       = newPC;
          w_id_valid_nxt = 1'b0;
          w_id_instr_nxt = NOP_INSTR;
        end else if (stall) begin
          if (imem_ready) begin
            w_skid_nxt  = imem_rdata;
            w_state_nxt = S_HOLD;
          end
        end else if (imem_ready) begin
          w_id_instr_nxt = imem_rdata;
          w_id_pc_nxt    = r_pc;
          w_id_valid_nxt = 1'b1;
          w_pc_nxt       = newPC;
        end else begin
          w_id_valid_nxt = 1'b0;
          w_id_instr_nxt = NOP_INSTR;
        end
      end
      S_HOLD: begin
        if (redirect && !stall) begin
          w_pc_nxt       = newPC;
          w_id_valid_nxt = 1'b0;
          w_id_instr_nxt = NOP_INSTR;
          w_skid_nxt     = 32'h0000_0000;
          w_state_nxt    = S_FETCH;
        end else if (!stall) begin
          w_id_instr_nxt = r_skid;
          w_id_pc_nxt    = r_pc;
          w_id_valid_nxt = 1'b1;
          w_pc_nxt       = newPC;
          w_skid_nxt     = 32'h0000_0000;
          w_state_nxt    = S_FETCH;
        end
      end
      default: begin
        w_state_nxt = S_BOOT;
      end
    endcase
  end

  assign imem_req  = w_req;
  assign imem_addr = r_pc;
  assign oldPC     = r_pc;
  assign id_pc     = r_id_pc;
  assign id_instr  = r_id_instr;
  assign id_valid  = r_id_valid;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb/tb_pc_fetch_unit.sv - scoreboard bench for pc_fetch_unit against a behavioural fetch model
module tb_pc_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_3000;
  localparam logic [31:0] NOP    = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] newPC = 32'h0;
  logic        redirect = 1'b0;
  logic        stall = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        imem_ready = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] oldPC;
  logic [31:0] id_pc;
  logic [31:0] id_instr;
  logic        id_valid;

  pc_fetch_unit #(.RESET_PC(RST_PC), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst_n(rst_n), .newPC(newPC), .redirect(redirect), .stall(stall),
    .imem_rdata(imem_rdata), .imem_ready(imem_ready), .imem_req(imem_req),
    .imem_addr(imem_addr), .oldPC(oldPC), .id_pc(id_pc), .id_instr(id_instr),
    .id_valid(id_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        req;
    logic [31:0] pc;
    logic [31:0] id_pc;
    logic [31:0] id_instr;
    logic        id_valid;
  } exp_t;

  exp_t q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Behavioural model: the fetch front end as "what is in ID" plus an optional
  // already-fetched word waiting for the stall to clear.
  logic [31:0] m_pc, m_id_pc, m_id_instr, m_held_word;
  logic        m_id_valid, m_idle, m_have_word;

  task automatic model_reset();
    m_pc = RST_PC; m_id_pc = 32'h0; m_id_instr = NOP; m_id_valid = 1'b0;
    m_idle = 1'b1; m_have_word = 1'b0; m_held_word = 32'h0;
  endtask

  task automatic model_bubble();
    m_id_valid = 1'b0; m_id_instr = NOP;
  endtask

  task automatic model_issue(input logic [31:0] word, input logic [31:0] npc);
    m_id_pc = m_pc; m_id_instr = word; m_id_valid = 1'b1; m_pc = npc;
  endtask

  task automatic model_step(input logic rdy, input logic [31:0] rd, input logic stl,
                            input logic rdr, input logic [31:0] npc);
    if (m_idle) begin
      m_idle = 1'b0;
    end else if (rdr && !stl) begin
      m_pc = npc; model_bubble(); m_have_word = 1'b0;
    end else if (stl) begin
      if (!m_have_word && rdy) begin
        m_have_word = 1'b1; m_held_word = rd;
      end
    end else if (m_have_word) begin
      model_issue(m_held_word, npc); m_have_word = 1'b0;
    end else if (rdy) begin
      model_issue(rd, npc);
    end else begin
      model_bubble();
    end
  endtask

  // One cycle of stimulus: apply inputs at the falling edge, record what the
  // DUT must show now, then advance the model across the coming rising edge.
  task automatic drive(input logic rst, input logic rdy, input logic [31:0] rd,
                       input logic stl, input logic rdr, input logic [31:0] npc);
    exp_t e;
    @(negedge clk);
    rst_n = rst; imem_ready = rdy; imem_rdata = rd; stall = stl;
    redirect = rdr; newPC = npc;
    if (!rst) model_reset();
    e.req = !m_idle && !m_have_word;
    e.pc = m_pc; e.id_pc = m_id_pc; e.id_instr = m_id_instr; e.id_valid = m_id_valid;
    q.push_back(e);
    if (rst) model_step(rdy, rd, stl, rdr, npc);
  endtask

  task automatic seq(input logic rdy, input logic stl);
    drive(1'b1, rdy, $urandom, stl, 1'b0, m_pc + 32'd4);
  endtask

  // Monitor: compares the DUT against each recorded expectation just after the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        vectors++;
        if (imem_req !== e.req || imem_addr !== e.pc || oldPC !== e.pc ||
            id_pc !== e.id_pc || id_instr !== e.id_instr || id_valid !== e.id_valid) begin
          miscompares++;
          $display("FAIL cycle_check t=%0t got req=%b addr=%h pc=%h id_pc=%h id_instr=%h id_valid=%b exp req=%b pc=%h id_pc=%h id_instr=%h id_valid=%b",
                   $time, imem_req, imem_addr, oldPC, id_pc, id_instr, id_valid,
                   e.req, e.pc, e.id_pc, e.id_instr, e.id_valid);
        end
      end
    end
  end

  initial begin
    model_reset();
    // Reset then boot idle cycle, then zero-wait sequential fetch.
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    drive(1'b0, 1'b1, 32'h1234_5678, 1'b0, 1'b0, 32'h0);
    seq(1'b1, 1'b0);
    seq(1'b1, 1'b0);
    // Two wait states at 3004.
    seq(1'b0, 1'b0);
    seq(1'b0, 1'b0);
    seq(1'b1, 1'b0);
    // Stall while data returns at 3008, stay stalled, then release.
    seq(1'b1, 1'b1);
    seq(1'b1, 1'b1);
    seq(1'b0, 1'b0);
    seq(1'b1, 1'b0);
    // Redirect at 3010 to 3040, then let it fetch.
    drive(1'b1, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b1, 32'h0000_3040);
    seq(1'b1, 1'b0);
    seq(1'b1, 1'b0);
    // Redirect under stall is ignored.
    drive(1'b1, 1'b0, 32'hAAAA_0001, 1'b1, 1'b1, 32'h0000_5000);
    // Enter hold, then redirect out of hold.
    seq(1'b1, 1'b1);
    drive(1'b1, 1'b0, 32'hAAAA_0002, 1'b0, 1'b1, 32'h0000_6000);
    seq(1'b1, 1'b0);
    // Enter hold again and reset mid-cycle.
    seq(1'b1, 1'b1);
    seq(1'b0, 1'b1);
    drive(1'b0, 1'b1, 32'h0, 1'b1, 1'b0, 32'h0);
    seq(1'b1, 1'b0);
    seq(1'b1, 1'b0);
    seq(1'b1, 1'b0);
    // Wrap-around of the PC with unaligned low bits passed through.
    drive(1'b1, 1'b1, $urandom, 1'b0, 1'b1, 32'hFFFF_FFFD);
    seq(1'b1, 1'b0);
    seq(1'b1, 1'b0);
    // Randomised traffic.
    for (int i = 0; i < 3000; i++) begin
      logic        r_rst, r_rdy, r_stl, r_rdr;
      logic [31:0] r_npc;
      r_rst = ($urandom_range(0, 199) != 0);
      r_rdy = ($urandom_range(0, 3) != 0);
      r_stl = ($urandom_range(0, 4) == 0);
      r_rdr = ($urandom_range(0, 7) == 0);
      r_npc = ($urandom_range(0, 4) == 0) ? $urandom : m_pc + 32'd4;
      drive(r_rst, r_rdy, $urandom, r_stl, r_rdr, r_npc);
    end
    @(negedge clk);
    @(posedge clk);
    if (q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL queue_drain got %0d pending expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
